// File: rtl/light_sequencer.sv
// Timed traffic-light sequencer: Red -> Green -> Yellow (-> Red+Walk) with pedestrian request latch.
// Define LIGHT_SEQ_WALK_EARLY_EN to let a pending walk request cut Green short after C_GREEN_MIN_MS.
module light_sequencer #(
    parameter int unsigned C_CLK_FRQ      = 100000000,
    parameter int unsigned C_RED_MS       = 3000,
    parameter int unsigned C_GREEN_MS     = 4000,
    parameter int unsigned C_YELLOW_MS    = 1000,
    parameter int unsigned C_WALK_MS      = 3000,
    parameter int unsigned C_GREEN_MIN_MS = 1500
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       inWalkReq,
    input  logic       inHold,
    output logic [1:0] outSel,
    output logic       outWalkPending,
    output logic       outPhaseDone
);

    localparam int unsigned P  = C_CLK_FRQ / 1000;
    localparam int unsigned PW = (P > 1) ? $clog2(P) : 1;
    localparam logic [PW-1:0] PrescLast = PW'(P - 1);

    localparam logic [15:0] RedLast      = 16'(C_RED_MS - 1);
    localparam logic [15:0] GreenLast    = 16'(C_GREEN_MS - 1);
    localparam logic [15:0] YellowLast   = 16'(C_YELLOW_MS - 1);
    localparam logic [15:0] WalkLast     = 16'(C_WALK_MS - 1);
    localparam logic [15:0] GreenMinLast = 16'(C_GREEN_MIN_MS - 1);

`ifdef LIGHT_SEQ_WALK_EARLY_EN
    localparam bit EarlyEn = 1'b1;
`else
    localparam bit EarlyEn = 1'b0;
`endif

    // Encoding doubles as the outSel code, so the output needs no decode.
    typedef enum logic [1:0] {
        StRed    = 2'b00,
        StGreen  = 2'b01,
        StYellow = 2'b10,
        StWalk   = 2'b11
    } state_e;

    state_e          stateQ, stateD;
    logic [PW-1:0]   prescQ, prescD;
    logic [15:0]     phaseQ, phaseD;
    logic            pendQ, pendD;
    logic            doneQ, doneD;

    logic            tick;
    logic            expire;
    logic            earlyCut;
    logic            enterWalk;
    logic [15:0]     durLast;

    always_comb begin
        tick      = 1'b0;
        expire    = 1'b0;
        earlyCut  = 1'b0;
        enterWalk = 1'b0;
        durLast   = RedLast;
        stateD    = stateQ;
        prescD    = prescQ;
        phaseD    = phaseQ;
        pendD     = pendQ;
        doneD     = 1'b0;

        tick = !inHold && (prescQ == PrescLast);

        unique case (stateQ)
            StRed:    durLast = RedLast;
            StGreen:  durLast = GreenLast;
            StYellow: durLast = YellowLast;
            StWalk:   durLast = WalkLast;
            default:  durLast = RedLast;
        endcase

        // A pending request may end Green at any tick once the minimum has elapsed.
        earlyCut = EarlyEn && (stateQ == StGreen) && pendQ && (phaseQ >= GreenMinLast);
        expire   = tick && ((phaseQ == durLast) || earlyCut);

        if (expire) begin
            unique case (stateQ)
                StRed:    stateD = StGreen;
                StGreen:  stateD = StYellow;
                StYellow: begin
                    if (pendQ || inWalkReq) begin
                        stateD    = StWalk;
                        enterWalk = 1'b1;
                    end else begin
                        stateD = StRed;
                    end
                end
                StWalk:   stateD = StRed;
                default:  stateD = StRed;
            endcase
        end

        if (!inHold) begin
            prescD = tick ? '0 : prescQ + PW'(1);
            if (expire) begin
                phaseD = '0;
            end else if (tick) begin
                phaseD = phaseQ + 16'd1;
            end
        end

        // Entering Walk consumes the request, including one arriving on that same edge.
        if (enterWalk) begin
            pendD = 1'b0;
        end else if (inWalkReq && (stateQ != StWalk)) begin
            pendD = 1'b1;
        end

        doneD = expire;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stateQ <= StRed;
            prescQ <= '0;
            phaseQ <= '0;
            pendQ  <= 1'b0;
            doneQ  <= 1'b0;
        end else begin
            stateQ <= stateD;
            prescQ <= prescD;
            phaseQ <= phaseD;
            pendQ  <= pendD;
            doneQ  <= doneD;
        end
    end

    assign outSel         = stateQ;
    assign outWalkPending = pendQ;
    assign outPhaseDone   = doneQ;

endmodule

// File: tb/tb_light_sequencer.sv
// Scoreboard bench for light_sequencer: stimulus pushes per-cycle expected outputs, a monitor checks them.
module tb_light_sequencer;

    localparam logic [1:0] SelRed    = 2'b00;
    localparam logic [1:0] SelGreen  = 2'b01;
    localparam logic [1:0] SelYellow = 2'b10;
    localparam logic [1:0] SelWalk   = 2'b11;

    logic       clk = 1'b0;
    logic       rst;
    logic       walkReq;
    logic       hold;
    logic [1:0] sel1, sel3;
    logic       pend1, pend3, done1, done3;

    always #5 clk = ~clk;

    light_sequencer #(
        .C_CLK_FRQ      (1000),
        .C_RED_MS       (4),
        .C_GREEN_MS     (6),
        .C_YELLOW_MS    (2),
        .C_WALK_MS      (3),
        .C_GREEN_MIN_MS (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .inWalkReq      (walkReq),
        .inHold         (hold),
        .outSel         (sel1),
        .outWalkPending (pend1),
        .outPhaseDone   (done1)
    );

    // P = 3; green minimum equals green so the early cut cannot change timing here.
    light_sequencer #(
        .C_CLK_FRQ      (3000),
        .C_RED_MS       (4),
        .C_GREEN_MS     (6),
        .C_YELLOW_MS    (2),
        .C_WALK_MS      (3),
        .C_GREEN_MIN_MS (6)
    ) dut3 (
        .clk            (clk),
        .rst            (rst),
        .inWalkReq      (walkReq),
        .inHold         (hold),
        .outSel         (sel3),
        .outWalkPending (pend3),
        .outPhaseDone   (done3)
    );

    typedef struct {
        bit         p3;
        logic [1:0] sel;
        logic       pend;
        logic       done;
        string      tag;
        int         idx;
    } exp_t;

    exp_t  expQ[$];
    int    checks = 0;
    int    errors = 0;
    string tag;
    bit    useP3;
    int    cycIdx;

    // Push n expected cycles with the current inputs held, advancing one clock per entry.
    task automatic seg(input int n, input logic [1:0] s, input logic p, input logic d0);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.p3   = useP3;
            e.sel  = s;
            e.pend = p;
            e.done = (i == 0) ? d0 : 1'b0;
            e.tag  = tag;
            e.idx  = cycIdx;
            expQ.push_back(e);
            cycIdx++;
            @(posedge clk);
            #1;
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t       e;
        logic [1:0] s;
        logic       p;
        logic       d;
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            s = e.p3 ? sel3 : sel1;
            p = e.p3 ? pend3 : pend1;
            d = e.p3 ? done3 : done1;
            checks++;
            if (s !== e.sel || p !== e.pend || d !== e.done) begin
                errors++;
                $display("FAIL %s cyc=%0d: got sel=%b pend=%b done=%b, expected sel=%b pend=%b done=%b",
                         e.tag, e.idx, s, p, d, e.sel, e.pend, e.done);
            end
        end
    end

    initial begin
        rst     = 1'b1;
        walkReq = 1'b0;
        hold    = 1'b0;
        useP3   = 1'b0;
        cycIdx  = 0;
        tag     = "reset";
        repeat (2) @(posedge clk);
        #1;
        seg(1, SelRed, 1'b0, 1'b0);
        rst = 1'b0;

        // Free-running cycle, two periods.
        tag = "s1_cycle"; cycIdx = 0;
        seg(4, SelRed, 1'b0, 1'b0);
        seg(6, SelGreen, 1'b0, 1'b1);
        seg(2, SelYellow, 1'b0, 1'b1);
        seg(4, SelRed, 1'b0, 1'b1);
        seg(6, SelGreen, 1'b0, 1'b1);
        seg(2, SelYellow, 1'b0, 1'b1);

        // Request in green cycle 1 leads to a walk phase.
        tag = "s2_walk"; cycIdx = 0;
        seg(4, SelRed, 1'b0, 1'b1);
        seg(1, SelGreen, 1'b0, 1'b1);
        walkReq = 1'b1;
        seg(1, SelGreen, 1'b0, 1'b0);
        walkReq = 1'b0;
`ifdef LIGHT_SEQ_WALK_EARLY_EN
        seg(1, SelGreen, 1'b1, 1'b0);
`else
        seg(4, SelGreen, 1'b1, 1'b0);
`endif
        seg(2, SelYellow, 1'b1, 1'b1);
        seg(3, SelWalk, 1'b0, 1'b1);
        seg(4, SelRed, 1'b0, 1'b1);

        // Hold for 5 cycles from green cycle 2 stretches green to 11.
        tag = "s3_hold"; cycIdx = 0;
        seg(1, SelGreen, 1'b0, 1'b1);
        seg(1, SelGreen, 1'b0, 1'b0);
        hold = 1'b1;
        seg(5, SelGreen, 1'b0, 1'b0);
        hold = 1'b0;
        seg(4, SelGreen, 1'b0, 1'b0);
        seg(2, SelYellow, 1'b0, 1'b1);
        seg(4, SelRed, 1'b0, 1'b1);

        // Reset (with hold also high) in yellow cycle 1 discards the pending request.
        tag = "s4_rst"; cycIdx = 0;
        seg(1, SelGreen, 1'b0, 1'b1);
        seg(4, SelGreen, 1'b0, 1'b0);
        walkReq = 1'b1;
        seg(1, SelGreen, 1'b0, 1'b0);
        walkReq = 1'b0;
        seg(1, SelYellow, 1'b1, 1'b1);
        rst  = 1'b1;
        hold = 1'b1;
        seg(1, SelYellow, 1'b1, 1'b0);
        rst  = 1'b0;
        hold = 1'b0;
        seg(4, SelRed, 1'b0, 1'b0);
        seg(6, SelGreen, 1'b0, 1'b1);
        seg(2, SelYellow, 1'b0, 1'b1);
        seg(4, SelRed, 1'b0, 1'b1);

        // Request in green cycle 0.
        tag = "s5_early"; cycIdx = 0;
        walkReq = 1'b1;
        seg(1, SelGreen, 1'b0, 1'b1);
        walkReq = 1'b0;
`ifdef LIGHT_SEQ_WALK_EARLY_EN
        seg(1, SelGreen, 1'b1, 1'b0);
`else
        seg(5, SelGreen, 1'b1, 1'b0);
`endif
        seg(2, SelYellow, 1'b1, 1'b1);
        seg(3, SelWalk, 1'b0, 1'b1);
        seg(4, SelRed, 1'b0, 1'b1);

        // P = 3 instance: collapsed requests, requests during walk ignored.
        tag = "s6_p3"; cycIdx = 0; useP3 = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        seg(1, SelRed, 1'b0, 1'b0);
        rst = 1'b0;
        seg(12, SelRed, 1'b0, 1'b0);
        walkReq = 1'b1;
        seg(1, SelGreen, 1'b0, 1'b1);
        seg(2, SelGreen, 1'b1, 1'b0);
        walkReq = 1'b0;
        seg(15, SelGreen, 1'b1, 1'b0);
        seg(6, SelYellow, 1'b1, 1'b1);
        walkReq = 1'b1;
        seg(9, SelWalk, 1'b0, 1'b1);
        walkReq = 1'b0;
        seg(12, SelRed, 1'b0, 1'b1);
        seg(18, SelGreen, 1'b0, 1'b1);
        seg(6, SelYellow, 1'b0, 1'b1);
        seg(12, SelRed, 1'b0, 1'b1);

        repeat (2) @(negedge clk);
        if (expQ.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected entries left unchecked, required 0", expQ.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached with %0d entries pending, required 0",
                 expQ.size());
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
